// File: rtl/ysyx_22050598_pipe_skid_buf.sv
// Two-entry valid/ready skid buffer for one pipeline stage boundary.
// Beats leave in acceptance order. s_ready and m_valid are decoded from the
// state register alone, so no combinational path crosses the stage. A
// synchronous flush drops every buffered beat.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   flush    synchronous discard of all buffered beats
//   s_valid  upstream beat valid
//   s_ready  buffer can accept a beat (registered)
//   s_data   upstream payload
//   m_valid  downstream beat valid (registered)
//   m_ready  downstream accepts
//   m_data   downstream payload, straight from the head register
//   count    occupancy 0..2
module ysyx_22050598_pipe_skid_buf #(
  parameter int unsigned   DW        = 64,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2,
    StBad   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          s_fire, m_fire;

  // The unused encoding decodes as empty.
  always_comb begin
    m_valid = (state_q == StOne) || (state_q == StFull);
    s_ready = (state_q != StFull);
    count   = m_valid ? state_q : 2'd0;
    m_data  = main_q;
  end

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers are left alone; only occupancy is cleared.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (s_fire) begin
            main_d  = s_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (s_fire && m_fire) begin
            main_d = s_data;
          end else if (s_fire) begin
            skid_d  = s_data;
            state_d = StFull;
          end else if (m_fire) begin
            // main_q keeps a stale value; m_valid masks it.
            state_d = StEmpty;
          end
        end
        StFull: begin
          // s_ready is low here, so only the drain case exists.
          if (m_fire) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_pipe_skid_buf.sv
module tb_ysyx_22050598_pipe_skid_buf;

  localparam int unsigned   DW    = 16;
  localparam logic [DW-1:0] RSTV  = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    count;

  int n_checks;
  int n_errors;

  ysyx_22050598_pipe_skid_buf #(
    .DW        (DW),
    .RESET_VAL (RSTV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_cnt);
    check({tag, ".count"},   64'(count),   64'(exp_cnt));
    check({tag, ".m_valid"}, 64'(m_valid), 64'(exp_cnt != 2'd0));
    check({tag, ".s_ready"}, 64'(s_ready), 64'(exp_cnt != 2'd2));
  endtask

  logic [DW-1:0] ref_q[$];
  int            mcnt;
  logic          sf, mf;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    #3;
    check_state("reset", 2'd0);
    check("reset.m_data", 64'(m_data), 64'(RSTV));
    tick();
    rst = 1'b0;
    tick();
    check_state("post_reset", 2'd0);

    // Streaming
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0010; tick();
    check_state("stream0", 2'd1); check("stream0.data", 64'(m_data), 64'h10);
    s_data  = 16'h0011; tick();
    check_state("stream1", 2'd1); check("stream1.data", 64'(m_data), 64'h11);
    s_data  = 16'h0012; tick();
    check_state("stream2", 2'd1); check("stream2.data", 64'(m_data), 64'h12);
    s_valid = 1'b0; tick();
    check_state("stream_drain", 2'd0);

    // Backpressure fill and drain
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h00A0; tick();
    check_state("bp0", 2'd1); check("bp0.data", 64'(m_data), 64'hA0);
    s_data  = 16'h00A1; tick();
    check_state("bp1", 2'd2); check("bp1.data", 64'(m_data), 64'hA0);
    s_data  = 16'h00A2; tick();
    check_state("bp_hold", 2'd2); check("bp_hold.data", 64'(m_data), 64'hA0);
    m_ready = 1'b1; tick();
    check_state("bp_out1", 2'd1); check("bp_out1.data", 64'(m_data), 64'hA1);
    tick();
    check_state("bp_out2", 2'd1); check("bp_out2.data", 64'(m_data), 64'hA2);
    s_valid = 1'b0; tick();
    check_state("bp_empty", 2'd0);

    // Simultaneous in/out while ONE
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h0055; tick();
    check("sim.data0", 64'(m_data), 64'h55);
    s_data  = 16'h0066;
    m_ready = 1'b1; tick();
    check_state("sim", 2'd1); check("sim.data1", 64'(m_data), 64'h66);
    s_valid = 1'b0; tick();
    check_state("sim_empty", 2'd0);

    // Flush with concurrent input, held two cycles
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h00B0; tick();
    s_data  = 16'h00B1; tick();
    check_state("fl_full", 2'd2);
    flush   = 1'b1;
    s_data  = 16'h00B2; tick();
    check_state("flush1", 2'd0);
    tick();
    check_state("flush2", 2'd0);
    flush   = 1'b0;
    s_data  = 16'h00C0; tick();
    check_state("after_flush", 2'd1); check("after_flush.data", 64'(m_data), 64'hC0);
    s_valid = 1'b0;
    m_ready = 1'b1; tick();
    check_state("after_flush_drain", 2'd0);

    // Asynchronous reset mid-cycle while FULL
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h00D0; tick();
    s_data  = 16'h00D1; tick();
    check_state("ar_full", 2'd2);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 2'd0);
    check("async_rst.data", 64'(m_data), 64'(RSTV));
    #1 rst = 1'b0;
    tick();
    check_state("async_rst_rel", 2'd0);

    // Random scoreboard against a FIFO reference
    mcnt = 0;
    for (int i = 0; i < 10000; i++) begin
      check("rnd.count", 64'(count), 64'(mcnt));
      check("rnd.m_valid", 64'(m_valid), 64'(mcnt != 0));
      check("rnd.s_ready", 64'(s_ready), 64'(mcnt != 2));
      if (mcnt != 0) check("rnd.data", 64'(m_data), 64'(ref_q[0]));
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      s_data  = DW'($urandom);
      sf = s_valid && (mcnt != 2);
      mf = m_ready && (mcnt != 0);
      if (flush) begin
        ref_q.delete();
      end else begin
        if (mf) void'(ref_q.pop_front());
        if (sf) ref_q.push_back(s_data);
      end
      mcnt = ref_q.size();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
